// File: rtl/exc_pkg.sv
// Shared cause codes, MEM exception flag positions, controller states and the priority encoder.
// Used by the exc_ctrl top and its synchroniser.
package exc_pkg;

    localparam int IRQ_W = 6;
    localparam int EXC_W = 8;

    localparam logic [4:0] EX_CODE_INT    = 5'h00;
    localparam logic [4:0] EX_CODE_HLT    = 5'h01;
    localparam logic [4:0] EX_CODE_RESUME = 5'h02;
    localparam logic [4:0] EX_CODE_ADEL   = 5'h04;
    localparam logic [4:0] EX_CODE_ADES   = 5'h05;
    localparam logic [4:0] EX_CODE_SYS    = 5'h08;
    localparam logic [4:0] EX_CODE_BP     = 5'h09;
    localparam logic [4:0] EX_CODE_RI     = 5'h0a;
    localparam logic [4:0] EX_CODE_OF     = 5'h0c;

    localparam int EXC_ADEL   = 0;
    localparam int EXC_RI     = 1;
    localparam int EXC_OF     = 2;
    localparam int EXC_SYS    = 3;
    localparam int EXC_BP     = 4;
    localparam int EXC_ADES   = 5;
    localparam int EXC_HLT    = 6;
    localparam int EXC_RESUME = 7;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Only meaningful when int_pend or some flag is set; the fall-through is never registered.
    function automatic logic [4:0] prio_code(input logic [EXC_W-1:0] exc, input logic int_pend);
        if (int_pend)                 return EX_CODE_INT;
        else if (exc[EXC_ADEL])       return EX_CODE_ADEL;
        else if (exc[EXC_RI])         return EX_CODE_RI;
        else if (exc[EXC_OF])         return EX_CODE_OF;
        else if (exc[EXC_SYS])        return EX_CODE_SYS;
        else if (exc[EXC_BP])         return EX_CODE_BP;
        else if (exc[EXC_ADES])       return EX_CODE_ADES;
        else if (exc[EXC_HLT])        return EX_CODE_HLT;
        else if (exc[EXC_RESUME])     return EX_CODE_RESUME;
        else                          return EX_CODE_INT;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-side, CP0-status and WB-side signals of exc_ctrl; master drives the pipeline side,
// slave is the controller.
interface exc_ctrl_if;

    logic                       stall;
    logic                       mem_valid;
    logic [31:0]                mem_pc;
    logic                       mem_bd;
    logic [exc_pkg::EXC_W-1:0]  mem_exc;
    logic                       mem_eret;
    logic [exc_pkg::IRQ_W-1:0]  irq_raw;
    logic                       cp0_ie;
    logic                       cp0_exl;
    logic                       cp0_hlt;
    logic [7:0]                 cp0_int_mask;
    logic [7:0]                 cp0_int_sig;

    logic [exc_pkg::IRQ_W-1:0]  irq_sync;
    logic                       ex_wb;
    logic [4:0]                 ex_code;
    logic [31:0]                epc;
    logic                       bd_wb;
    logic                       eret_flush;

    modport master (
        output stall, mem_valid, mem_pc, mem_bd, mem_exc, mem_eret, irq_raw,
               cp0_ie, cp0_exl, cp0_hlt, cp0_int_mask, cp0_int_sig,
        input  irq_sync, ex_wb, ex_code, epc, bd_wb, eret_flush
    );

    modport slave (
        input  stall, mem_valid, mem_pc, mem_bd, mem_exc, mem_eret, irq_raw,
               cp0_ie, cp0_exl, cp0_hlt, cp0_int_mask, cp0_int_sig,
        output irq_sync, ex_wb, ex_code, epc, bd_wb, eret_flush
    );

endinterface

// File: rtl/exc_ctrl_irq_sync.sv
// Level synchroniser for the raw interrupt lines: SYNC_STAGES flops per bit, output lags input
// by SYNC_STAGES cycles, no backpressure.
module irq_sync
    import exc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] irq_raw,
    output logic [IRQ_W-1:0] irq_out
);

    logic [IRQ_W-1:0] chain [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= irq_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign irq_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// WB-side exception/ERET register for cp0 with post-flush drain and halt/resume sequencing.
// Pulses appear the cycle after an accepted MEM instruction; stall holds off capture entirely.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.slave  bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic        halt_next;
    logic        ex_wb_q;
    logic        eret_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q;
    logic        bd_q;

    logic        int_pend;
    logic        accept;
    logic        exc_active;
    logic [4:0]  nxt_code;
    logic        hlt_unused;

    // cp0_exl is already the registered CP0 value, so a same-cycle EXL rise masks the interrupt.
    assign int_pend   = bus.cp0_ie & ~bus.cp0_exl & (|(bus.cp0_int_sig & bus.cp0_int_mask));
    assign accept     = bus.mem_valid & ~bus.stall;
    assign exc_active = int_pend | (|bus.mem_exc);
    assign nxt_code   = prio_code(bus.mem_exc, int_pend);
    assign hlt_unused = bus.cp0_hlt;

    irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .rst     (rst),
        .irq_raw (bus.irq_raw),
        .irq_out (bus.irq_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            halt_next <= 1'b0;
            ex_wb_q   <= 1'b0;
            eret_q    <= 1'b0;
            code_q    <= '0;
            epc_q     <= '0;
            bd_q      <= 1'b0;
        end else begin
            ex_wb_q <= 1'b0;
            eret_q  <= 1'b0;
            case (state)
                RUN: begin
                    if (accept && exc_active) begin
                        ex_wb_q   <= 1'b1;
                        code_q    <= nxt_code;
                        epc_q     <= bus.mem_pc;
                        bd_q      <= bus.mem_bd;
                        halt_next <= (nxt_code == EX_CODE_HLT);
                        cnt       <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end else if (accept && bus.mem_eret) begin
                        eret_q    <= 1'b1;
                        halt_next <= 1'b0;
                        cnt       <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Counts down through stalls; the last drain cycle is the one where cnt reads 1.
                    if (cnt <= 4'd1) begin
                        cnt   <= '0;
                        state <= halt_next ? HALT : RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HALT: begin
                    if (accept && bus.mem_exc[EXC_RESUME]) begin
                        ex_wb_q   <= 1'b1;
                        code_q    <= EX_CODE_RESUME;
                        epc_q     <= bus.mem_pc;
                        bd_q      <= bus.mem_bd;
                        halt_next <= 1'b0;
                        cnt       <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.ex_wb      = ex_wb_q;
    assign bus.eret_flush = eret_q;
    assign bus.ex_code    = code_q;
    assign bus.epc        = epc_q;
    assign bus.bd_wb      = bd_q & ~(hlt_unused & 1'b0);

endmodule
